data_mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer in front of the 16x32 data memory.

---
 rtl/data_mem_arbiter.sv | 99 +++++++++
 tb/tb_data_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Each granted transaction runs IDLE -> ACCESS -> RESP with registered outputs.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_p0_req,
   input  logic              i_p0_we,
   input  logic [ADDR_W-1:0] i_p0_addr,
   input  logic [DATA_W-1:0] i_p0_wdata,
   output logic              o_p0_ack,
   output logic [DATA_W-1:0] o_p0_rdata,
   input  logic              i_p1_req,
   input  logic              i_p1_we,
   input  logic [ADDR_W-1:0] i_p1_addr,
   input  logic [DATA_W-1:0] i_p1_wdata,
   output logic              o_p1_ack,
   output logic [DATA_W-1:0] o_p1_rdata,
   output logic              o_mem_st,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_busy,
   output logic              o_grant_id
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

   state_t              r_state;
   logic                r_grant;
   logic                r_mem_st;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_p0_ack;
   logic                r_p1_ack;
   logic [DATA_W-1:0]   r_p0_rdata;
   logic [DATA_W-1:0]   r_p1_rdata;

   logic                w_any_req;
   logic                w_win;

   assign w_any_req = i_p0_req | i_p1_req;
   // On contention the port that did not win last time gets the slot.
   assign w_win     = (i_p0_req & i_p1_req) ? ~r_grant : i_p1_req;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= StIdle;
         r_grant     <= 1'b1;
         r_mem_st    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_p0_ack    <= 1'b0;
         r_p1_ack    <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
      end else begin
         r_p0_ack <= 1'b0;
         r_p1_ack <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_any_req) begin
                  r_state     <= StAccess;
                  r_grant     <= w_win;
                  r_mem_st    <= w_win ? i_p1_we    : i_p0_we;
                  r_mem_addr  <= w_win ? i_p1_addr  : i_p0_addr;
                  r_mem_wdata <= w_win ? i_p1_wdata : i_p0_wdata;
               end
            end
            StAccess: begin
               r_state  <= StResp;
               r_mem_st <= 1'b0;
               if (!r_mem_st) begin
                  if (r_grant) r_p1_rdata <= i_mem_rdata;
                  else         r_p0_rdata <= i_mem_rdata;
               end
               if (r_grant) r_p1_ack <= 1'b1;
               else         r_p0_ack <= 1'b1;
            end
            StResp:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   // Gated by reset so a write whose commit edge coincides with reset is dropped.
   assign o_mem_st    = r_mem_st & i_reset;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_p0_ack    = r_p0_ack;
   assign o_p1_ack    = r_p1_ack;
   assign o_p0_rdata  = r_p0_rdata;
   assign o_p1_rdata  = r_p1_rdata;
   assign o_busy      = (r_state != StIdle);
   assign o_grant_id  = r_grant;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 16x32 memory model behind the memory port.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [3:0]  p0_addr = '0, p1_addr = '0;
   logic [31:0] p0_wdata = '0, p1_wdata = '0;
   logic        p0_ack, p1_ack, mem_st, busy, grant_id;
   logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
   logic [3:0]  mem_addr;
   logic        mem_init = 1'b1;
   logic [31:0] mem [16];

   int n_checks = 0;
   int n_errors = 0;

   data_mem_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
      .o_p0_ack(p0_ack), .o_p0_rdata(p0_rdata),
      .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
      .o_p1_ack(p1_ack), .o_p1_rdata(p1_rdata),
      .o_mem_st(mem_st), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .o_busy(busy), .o_grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Memory model: word i starts as 0x1000_0000 + i; combinational read.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
      end else if (mem_st) begin
         mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr];

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int     acks;
      logic   seq [6];
      logic   overlap;

      // 1. reset
      tick();
      tick();
      mem_init = 1'b0;
      chk("rst_p0_ack", p0_ack, 0);
      chk("rst_p1_ack", p1_ack, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_mem_st", mem_st, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_id, 1);
      reset = 1'b1;
      tick(); tick(); tick();
      chk("idle_mem_st", mem_st, 0);
      chk("idle_busy", busy, 0);

      // 2. p0 write then read addr 3
      p0_req = 1; p0_we = 1; p0_addr = 4'd3; p0_wdata = 32'hDEADBEEF;
      tick();
      chk("wr_acc_st", mem_st, 1);
      chk("wr_acc_addr", mem_addr, 3);
      chk("wr_acc_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_acc_busy", busy, 1);
      chk("wr_acc_grant", grant_id, 0);
      chk("wr_acc_noack", p0_ack, 0);
      tick();
      chk("wr_resp_ack", p0_ack, 1);
      chk("wr_resp_st", mem_st, 0);
      chk("wr_mem3", mem[3], 32'hDEADBEEF);
      chk("wr_rdata_kept", p0_rdata, 0);
      p0_req = 0;
      tick();
      chk("wr_idle_ack", p0_ack, 0);
      chk("wr_idle_busy", busy, 0);
      p0_req = 1; p0_we = 0; p0_addr = 4'd3;
      tick();
      chk("rd_acc_st", mem_st, 0);
      chk("rd_acc_addr", mem_addr, 3);
      tick();
      chk("rd_resp_ack", p0_ack, 1);
      chk("rd_resp_rdata", p0_rdata, 32'hDEADBEEF);
      p0_req = 0;
      tick();

      // 3. simultaneous requests after a fresh reset: p0 then p1
      reset = 0;
      tick();
      reset = 1;
      chk("rst2_grant", grant_id, 1);
      p0_req = 1; p0_we = 0; p0_addr = 4'd2;
      p1_req = 1; p1_we = 0; p1_addr = 4'd5;
      tick();
      chk("both_acc_grant0", grant_id, 0);
      chk("both_acc_addr2", mem_addr, 2);
      tick();
      chk("both_p0_ack", p0_ack, 1);
      chk("both_p1_noack", p1_ack, 0);
      chk("both_p0_rdata", p0_rdata, 32'h1000_0002);
      p0_req = 0;
      tick();
      chk("both_gap_busy", busy, 0);
      tick();
      chk("both_acc_grant1", grant_id, 1);
      chk("both_acc_addr5", mem_addr, 5);
      tick();
      chk("both_p1_ack", p1_ack, 1);
      chk("both_p0_noack", p0_ack, 0);
      chk("both_p1_rdata", p1_rdata, 32'h1000_0005);
      chk("both_p0_rdata_kept", p0_rdata, 32'h1000_0002);
      chk("mem3_survives_rst", mem[3], 32'hDEADBEEF);
      p1_req = 0;
      tick();

      // 4. p1 holds req, p0 re-requests after each ack: strict alternation
      acks = 0;
      overlap = 0;
      p0_req = 1;
      p1_req = 1;
      for (int c = 0; c < 18; c++) begin
         tick();
         if (p0_ack && p1_ack) overlap = 1;
         if (p0_ack || p1_ack) begin
            if (acks < 6) seq[acks] = p1_ack;
            acks++;
         end
         p0_req = !p0_ack;
      end
      p0_req = 0;
      p1_req = 0;
      chk("rr_no_overlap", overlap, 0);
      chk("rr_ack_count", acks, 6);
      for (int k = 0; k < 6; k++) chk($sformatf("rr_seq%0d", k), seq[k], k % 2);
      tick();

      // 5. command changes and req drop after grant do not affect the op
      p0_req = 1; p0_we = 1; p0_addr = 4'd3; p0_wdata = 32'hCAFEF00D;
      tick();
      chk("late_acc_addr", mem_addr, 3);
      p0_req = 0; p0_addr = 4'd7; p0_wdata = 32'h0BADF00D;
      tick();
      chk("late_ack", p0_ack, 1);
      chk("late_mem3", mem[3], 32'hCAFEF00D);
      chk("late_mem7", mem[7], 32'h1000_0007);
      tick();
      p1_req = 1; p1_we = 0; p1_addr = 4'd3;
      tick();
      chk("raw_grant", grant_id, 1);
      tick();
      chk("raw_p1_ack", p1_ack, 1);
      chk("raw_p1_rdata", p1_rdata, 32'hCAFEF00D);
      chk("raw_p0_rdata_kept", p0_rdata, 32'h1000_0002);
      p1_req = 0;
      tick();

      // 6. reset during the ACCESS cycle of a write aborts it
      p0_req = 1; p0_we = 1; p0_addr = 4'd9; p0_wdata = 32'h12345678;
      tick();
      chk("abort_acc_st", mem_st, 1);
      reset = 0;
      p0_req = 0;
      #1;
      chk("abort_st_gated", mem_st, 0);
      tick();
      chk("abort_noack", p0_ack, 0);
      chk("abort_st", mem_st, 0);
      chk("abort_busy", busy, 0);
      chk("abort_mem9", mem[9], 32'h1000_0009);
      reset = 1;
      tick();
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_ack", p0_ack, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
